// File: rtl/transfer_scheduler_pkg.sv
// Shared types and constants for the two-channel burst scheduler.
package transfer_scheduler_pkg;

    // Engine sequencing states of the shared copy engine.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DROP = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    // Largest burst the engine accepts, and the width that holds 1..MAX_BURST.
    localparam int MAX_BURST = 256;
    localparam int LEN_W     = 9;

    // Channel indices, also used as the grant encoding.
    localparam logic CH0 = 1'b0;
    localparam logic CH1 = 1'b1;

endpackage

// File: rtl/scheduler_channel.sv
// Per-channel transfer bookkeeping: captures a request, splits it into
// bursts, advances the addresses after each issued burst and signals completion.
module scheduler_channel
    import transfer_scheduler_pkg::*;
#(
    parameter int REG_W  = 32,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              start,
    input  logic [REG_W-1:0]  transfer_size,
    input  logic [REG_W-1:0]  burst_size,
    input  logic [REG_W-1:0]  write_address,
    input  logic [REG_W-1:0]  read_address,
    input  logic              write_coherent,
    input  logic              read_coherent,
    input  logic              issue,
    input  logic              finish,
    output logic              busy,
    output logic              done,
    output logic              pending,
    output logic              remaining_zero,
    output logic [LEN_W-1:0]  burst_len,
    output logic [ADDR_W-1:0] write_addr_cur,
    output logic [ADDR_W-1:0] read_addr_cur,
    output logic              write_coh,
    output logic              read_coh
);

    localparam int BYTES_PER_BEAT = DATA_W / 8;

    logic [REG_W-1:0]  remaining;
    logic [LEN_W-1:0]  eff_burst;
    logic [LEN_W-1:0]  burst_clamped;
    logic [ADDR_W-1:0] addr_step;
    logic              zero_size;

    // Clamp the requested burst size into 1..MAX_BURST before capture.
    always_comb begin
        // NOTE: default first so every path assigns and no latch is inferred.
        burst_clamped = burst_size[LEN_W-1:0];
        if (burst_size == '0) begin
            burst_clamped = LEN_W'(1);
        end else if (burst_size > REG_W'(MAX_BURST)) begin
            burst_clamped = LEN_W'(MAX_BURST);
        end
    end

    assign remaining_zero = (remaining == '0);
    assign pending        = busy && !remaining_zero;
    assign burst_len      = (remaining < REG_W'(eff_burst)) ? remaining[LEN_W-1:0] : eff_burst;
    assign addr_step      = ADDR_W'(burst_len) * ADDR_W'(BYTES_PER_BEAT);

    // Capture on start, count down per issued burst, retire on finish.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            busy           <= 1'b0;
            done           <= 1'b0;
            zero_size      <= 1'b0;
            remaining      <= '0;
            eff_burst      <= '0;
            write_addr_cur <= '0;
            read_addr_cur  <= '0;
            write_coh      <= 1'b0;
            read_coh       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register update in the same edge.
            done <= 1'b0;
            if (finish || (busy && zero_size)) begin
                // Completion also blocks a same-cycle start because busy is still high.
                busy      <= 1'b0;
                done      <= 1'b1;
                zero_size <= 1'b0;
            end else if (start && !busy) begin
                busy           <= 1'b1;
                zero_size      <= (transfer_size == '0);
                remaining      <= transfer_size;
                eff_burst      <= burst_clamped;
                write_addr_cur <= write_address[ADDR_W-1:0];
                read_addr_cur  <= read_address[ADDR_W-1:0];
                write_coh      <= write_coherent;
                read_coh       <= read_coherent;
            end else if (issue) begin
                remaining      <= remaining - REG_W'(burst_len);
                write_addr_cur <= write_addr_cur + addr_step;
                read_addr_cur  <= read_addr_cur + addr_step;
            end
        end
    end

endmodule

// File: rtl/transfer_scheduler.sv
// Round-robin burst scheduler sharing one copy engine between two channels.
// Picks a pending channel, latches its burst configuration and walks the
// engine through enable, ready-drop and ready-return.
module transfer_scheduler
    import transfer_scheduler_pkg::*;
#(
    parameter int C_registers_DATA_WIDTH = 32,
    parameter int C_data_ADDR_WIDTH      = 32,
    parameter int C_data_DATA_WIDTH      = 32
) (
    input  logic                              aclk,
    input  logic                              aresetn,
    input  logic                              ch0_start,
    input  logic [C_registers_DATA_WIDTH-1:0] ch0_transfer_size,
    input  logic [C_registers_DATA_WIDTH-1:0] ch0_burst_size,
    input  logic [C_registers_DATA_WIDTH-1:0] ch0_write_address,
    input  logic [C_registers_DATA_WIDTH-1:0] ch0_read_address,
    input  logic                              ch0_write_coherent,
    input  logic                              ch0_read_coherent,
    output logic                              ch0_busy,
    output logic                              ch0_done,
    input  logic                              ch1_start,
    input  logic [C_registers_DATA_WIDTH-1:0] ch1_transfer_size,
    input  logic [C_registers_DATA_WIDTH-1:0] ch1_burst_size,
    input  logic [C_registers_DATA_WIDTH-1:0] ch1_write_address,
    input  logic [C_registers_DATA_WIDTH-1:0] ch1_read_address,
    input  logic                              ch1_write_coherent,
    input  logic                              ch1_read_coherent,
    output logic                              ch1_busy,
    output logic                              ch1_done,
    output logic                              data_enable,
    input  logic                              write_ready,
    input  logic                              read_ready,
    output logic [C_registers_DATA_WIDTH-1:0] burst_length_con,
    output logic [C_registers_DATA_WIDTH-1:0] write_address_con,
    output logic [C_registers_DATA_WIDTH-1:0] read_address_con,
    output logic [C_registers_DATA_WIDTH-1:0] write_coherency_flag_con,
    output logic [C_registers_DATA_WIDTH-1:0] read_coherency_flag_con
);

    localparam int REG_W  = C_registers_DATA_WIDTH;
    localparam int ADDR_W = C_data_ADDR_WIDTH;

    state_t state;
    logic   grant;          // channel granted most recently
    logic   sel;
    logic   engine_idle;
    logic   launch;
    logic   engine_done;

    logic              pending0, pending1;
    logic              rem_zero0, rem_zero1;
    logic              issue0, issue1;
    logic              finish0, finish1;
    logic [LEN_W-1:0]  len0, len1;
    logic [ADDR_W-1:0] wr0, wr1, rd0, rd1;
    logic              wcoh0, wcoh1, rcoh0, rcoh1;

    scheduler_channel #(
        .REG_W (REG_W),
        .ADDR_W(ADDR_W),
        .DATA_W(C_data_DATA_WIDTH)
    ) u_ch0 (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .start         (ch0_start),
        .transfer_size (ch0_transfer_size),
        .burst_size    (ch0_burst_size),
        .write_address (ch0_write_address),
        .read_address  (ch0_read_address),
        .write_coherent(ch0_write_coherent),
        .read_coherent (ch0_read_coherent),
        .issue         (issue0),
        .finish        (finish0),
        .busy          (ch0_busy),
        .done          (ch0_done),
        .pending       (pending0),
        .remaining_zero(rem_zero0),
        .burst_len     (len0),
        .write_addr_cur(wr0),
        .read_addr_cur (rd0),
        .write_coh     (wcoh0),
        .read_coh      (rcoh0)
    );

    scheduler_channel #(
        .REG_W (REG_W),
        .ADDR_W(ADDR_W),
        .DATA_W(C_data_DATA_WIDTH)
    ) u_ch1 (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .start         (ch1_start),
        .transfer_size (ch1_transfer_size),
        .burst_size    (ch1_burst_size),
        .write_address (ch1_write_address),
        .read_address  (ch1_read_address),
        .write_coherent(ch1_write_coherent),
        .read_coherent (ch1_read_coherent),
        .issue         (issue1),
        .finish        (finish1),
        .busy          (ch1_busy),
        .done          (ch1_done),
        .pending       (pending1),
        .remaining_zero(rem_zero1),
        .burst_len     (len1),
        .write_addr_cur(wr1),
        .read_addr_cur (rd1),
        .write_coh     (wcoh1),
        .read_coh      (rcoh1)
    );

    // On a tie the channel not granted last wins; otherwise the lone pending one.
    assign sel         = (pending0 && pending1) ? ~grant : pending1;
    assign engine_idle = write_ready && read_ready;
    assign launch      = (state == IDLE) && (pending0 || pending1) && engine_idle;
    assign engine_done = (state == WAIT_DONE) && engine_idle;

    assign issue0  = launch && (sel == CH0);
    assign issue1  = launch && (sel == CH1);
    assign finish0 = engine_done && (grant == CH0) && rem_zero0;
    assign finish1 = engine_done && (grant == CH1) && rem_zero1;

    // Engine sequencer: latch grant and burst config, pulse enable, track readies.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state                    <= IDLE;
            grant                    <= CH1;
            data_enable              <= 1'b0;
            burst_length_con         <= '0;
            write_address_con        <= '0;
            read_address_con         <= '0;
            write_coherency_flag_con <= '0;
            read_coherency_flag_con  <= '0;
        end else begin
            data_enable <= 1'b0;
            case (state)
                IDLE: begin
                    if (launch) begin
                        grant       <= sel;
                        data_enable <= 1'b1;
                        state       <= ISSUE;
                        if (sel == CH1) begin
                            burst_length_con         <= REG_W'(len1);
                            write_address_con        <= REG_W'(wr1);
                            read_address_con         <= REG_W'(rd1);
                            write_coherency_flag_con <= REG_W'(wcoh1);
                            read_coherency_flag_con  <= REG_W'(rcoh1);
                        end else begin
                            burst_length_con         <= REG_W'(len0);
                            write_address_con        <= REG_W'(wr0);
                            read_address_con         <= REG_W'(rd0);
                            write_coherency_flag_con <= REG_W'(wcoh0);
                            read_coherency_flag_con  <= REG_W'(rcoh0);
                        end
                    end
                end
                ISSUE:     state <= WAIT_DROP;
                WAIT_DROP: if (!engine_idle) state <= WAIT_DONE;
                WAIT_DONE: if (engine_idle)  state <= IDLE;
                default:   state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/transfer_scheduler.md
# transfer_scheduler

Burst-level scheduler that shares one `data_module` copy engine between two transfer requesters (channel 0, channel 1). It splits each channel's transfer into bursts and grants the engine round-robin per burst. For each burst it presents the engine's `*_con` configuration and sequences it through `enable`, `write_ready` and `read_ready`. It sits between the per-channel register/descriptor logic and `data_module`, replacing the single-requester control path.

## Interface
**Parameters**
- `C_registers_DATA_WIDTH`, default 32: width of size, address and flag words.
- `C_data_ADDR_WIDTH`, default 32: engine address width; addresses wrap modulo 2^this.
- `C_data_DATA_WIDTH`, default 32: beat width; the byte stride per beat is this/8.

**Ports** (x ∈ {0,1})
- `aclk`, in, 1: the only clock.
- `aresetn`, in, 1: reset, asynchronous, active-low.
- `chx_start`, in, 1: single-cycle request; sampled only while `chx_busy`=0.
- `chx_transfer_size`, in, REG_W: total beats; captured on start.
- `chx_burst_size`, in, REG_W: beats per burst; captured on start.
- `chx_write_address`, in, REG_W: destination byte address; captured on start.
- `chx_read_address`, in, REG_W: source byte address; captured on start.
- `chx_write_coherent`, in, 1: coherency flag; captured on start.
- `chx_read_coherent`, in, 1: coherency flag; captured on start.
- `chx_busy`, out, 1: channel holds an accepted transfer.
- `chx_done`, out, 1: one-cycle pulse when the transfer completes.
- `data_enable`, out, 1: one-cycle burst launch pulse to the engine.
- `write_ready`, in, 1: engine write side idle.
- `read_ready`, in, 1: engine read side idle.
- `burst_length_con`, out, REG_W: beats in the current burst (1..256).
- `write_address_con`, out, REG_W: write address for the current burst.
- `read_address_con`, out, REG_W: read address for the current burst.
- `write_coherency_flag_con`, out, REG_W: zero-extended write flag.
- `read_coherency_flag_con`, out, REG_W: zero-extended read flag.

## Operation
**Capture on start**
- `burst_size` 0 is treated as 1; values above 256 are clamped to 256.
- `transfer_size` 0 sets busy for exactly one cycle, then pulses done. No burst is issued.

**Per-burst values**
- len = min(effective burst size, remaining).
- After each issue: remaining -= len; both addresses += len×(C_data_DATA_WIDTH/8), truncated to the address width.

**Arbitration**
- A channel is pending when it is busy with remaining > 0.
- If both are pending, the channel not granted last wins.
- Reset sets last grant to channel 1, so channel 0 wins the first tie.

**FSM states**
- IDLE: if any channel is pending and `write_ready`&`read_ready` = 1, latch the grant and `*_con` values → ISSUE.
- ISSUE: `data_enable`=1 for exactly one cycle → WAIT_DROP.
- WAIT_DROP: wait until `write_ready`&`read_ready` = 0 → WAIT_DONE.
- WAIT_DONE: wait until both are 1.
  - If the granted channel's remaining = 0: pulse `chx_done`, clear `chx_busy`.
  - Go to IDLE.

**Concurrency and reset**
- A start on an idle channel is accepted in any FSM state.
- A start while that channel is busy is ignored.
- Start and done on the same channel in the same cycle: done wins, and the start is ignored.
- Reset mid-operation:
  - Every register clears immediately.
  - Any outstanding burst is abandoned.
  - The engine must be reset by the same `aresetn`.

## Timing
- Reset values:
  - `chx_busy`, `chx_done`, `data_enable` = 0.
  - All `*_con` = 0.
  - FSM = IDLE.
- Start sampled at edge t: `chx_busy`=1 from t+1. If the engine is idle, IDLE is evaluated at t+1 and `data_enable`=1 in cycle t+2.
- `*_con` are registered. They are stable from the ISSUE cycle until the next IDLE→ISSUE transition.
- Minimum burst-to-burst spacing is 4 cycles when the engine drops its readies one cycle after enable.
- `chx_done` is asserted in the cycle after WAIT_DONE sees both readies high. `chx_busy` falls in that same cycle.

## Structure
- Package `transfer_scheduler_pkg` holds:
  - the FSM state enum (IDLE, ISSUE, WAIT_DROP, WAIT_DONE);
  - `MAX_BURST` = 256;
  - the channel index constants.
- Sub-module `scheduler_channel`, instantiated twice, contains:
  - capture registers, remaining counter, address counters;
  - burst length computation;
  - busy/done generation.
- The top level contains the arbiter and the FSM.

## Test plan
- **Single channel.** ch0 with size 10, burst 4, wr 0x1000, rd 0x2000.
  - Three bursts: len 4/4/2.
  - Write addresses 0x1000/0x1010/0x1020; read addresses 0x2000/0x2010/0x2020.
  - One `ch0_done` pulse.
- **Interleaving.** Both channels start in the same cycle, each with size 8, burst 4.
  - Grant order: ch0, ch1, ch0, ch1.
  - ch0 done precedes ch1 done.
- **Clamping and zero size.**
  - burst_size 0 → len 1.
  - burst_size 300 with size 600 → lens 256/256/88.
  - transfer_size 0 → busy for 1 cycle, then done, with no `data_enable`.
- **Address wrap.** wr 0xFFFFFFF8, size 4, burst 2: second burst write address = 0x00000000.
- **Start while busy.** Second `ch1_start` during a transfer is ignored: no extra bursts, and the captured fields are unchanged.
- **Reset mid-burst.** `aresetn` low in WAIT_DONE → all outputs are 0 the same cycle. After release, a fresh ch0 transfer completes normally.
